divider_seq_ctrl: RTL and testbench

//  Iterative controller for the 16/8 unsigned restoring divider. Reuses one 8-cell subtractor row over 8 cycles instead of a full array.

---
 rtl/div_ctrl_pkg.sv | 14 +
 rtl/div_row8.sv | 25 ++
 rtl/divider_seq_ctrl.sv | 134 +++++++++++++
 tb/tb_divider_seq_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared types and widths for the sequenced 16/8 restoring divider controller.
package div_ctrl_pkg;

  localparam int N_W   = 16;
  localparam int D_W   = 8;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_row8.sv
// One 8-cell ripple-borrow subtractor row computing x - y; every cell switches
// to the approximate borrow (bout = ~bin) when approx_i is set.
module div_row8
  import div_ctrl_pkg::*;
(
  input  logic [D_W-1:0] x_i,
  input  logic [D_W-1:0] y_i,
  input  logic           approx_i,
  output logic [D_W-1:0] diff_o,
  output logic           bout_msb_o
);

  always_comb begin
    logic b;
    b      = 1'b0;
    diff_o = '0;
    for (int j = 0; j < D_W; j++) begin
      diff_o[j] = x_i[j] ^ y_i[j] ^ b;
      if (approx_i) b = ~b;
      else          b = (~x_i[j] & y_i[j]) | (~(x_i[j] ^ y_i[j]) & b);
    end
    bout_msb_o = b;
  end

endmodule

// File: rtl/divider_seq_ctrl.sv
// Iterative 16/8 unsigned restoring divider: one subtractor row reused over
// eight cycles, with divide-by-zero and quotient-overflow short-cuts.
module divider_seq_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int APPROX_ROWS = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N_W-1:0] in_n,
  input  logic [D_W-1:0] in_d,
  input  logic           in_approx,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [D_W-1:0] out_q,
  output logic [D_W-1:0] out_r,
  output logic           out_dz,
  output logic           out_ovf
);

  state_t            state_q, state_d;
  logic [D_W-1:0]    n_lo_q, n_lo_d;
  logic [D_W-1:0]    d_q, d_d;
  logic              approx_q, approx_d;
  logic [D_W-1:0]    rem_q, rem_d;
  logic [D_W-1:0]    quo_q, quo_d;
  logic [CNT_W-1:0]  k_q, k_d;
  logic              dz_q, dz_d;
  logic              ovf_q, ovf_d;

  logic [D_W:0]      t;
  logic [D_W-1:0]    row_diff;
  logic              row_bout;
  logic              row_approx;
  logic              qbit;

  // Shifted partial remainder: the dividend bit for this row enters at the LSB.
  assign t          = {rem_q, n_lo_q[k_q]};
  assign row_approx = approx_q && (32'(k_q) < APPROX_ROWS);
  assign qbit       = t[D_W] | ~row_bout;

  div_row8 u_row (
    .x_i        (t[D_W-1:0]),
    .y_i        (d_q),
    .approx_i   (row_approx),
    .diff_o     (row_diff),
    .bout_msb_o (row_bout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      n_lo_q   <= '0;
      d_q      <= '0;
      approx_q <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      k_q      <= '0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_lo_q   <= n_lo_d;
      d_q      <= d_d;
      approx_q <= approx_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      k_q      <= k_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    n_lo_d   = n_lo_q;
    d_d      = d_q;
    approx_d = approx_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    k_d      = k_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          n_lo_d   = in_n[D_W-1:0];
          d_d      = in_d;
          approx_d = in_approx;
          k_d      = CNT_W'(D_W - 1);
          dz_d     = 1'b0;
          ovf_d    = 1'b0;
          if (in_d == '0) begin
            dz_d    = 1'b1;
            quo_d   = '1;
            rem_d   = in_n[D_W-1:0];
            state_d = DONE;
          end else if (in_n[N_W-1:D_W] >= in_d) begin
            ovf_d   = 1'b1;
            quo_d   = '1;
            rem_d   = in_n[D_W-1:0];
            state_d = DONE;
          end else begin
            quo_d   = '0;
            rem_d   = in_n[N_W-1:D_W];
            state_d = CALC;
          end
        end
      end
      CALC: begin
        quo_d[k_q] = qbit;
        rem_d      = qbit ? row_diff : t[D_W-1:0];
        // Counter holds at zero; leaving CALC is what ends the iteration.
        if (k_q == '0) state_d = DONE;
        else           k_d     = k_q - 1'b1;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign out_q     = quo_q;
  assign out_r     = rem_q;
  assign out_dz    = dz_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_divider_seq_ctrl.sv
// Randomized self-checking bench for divider_seq_ctrl against an arithmetic reference.
module tb_divider_seq_ctrl;

  localparam int AR = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_n;
  logic [7:0]  in_d;
  logic        in_approx;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_q;
  logic [7:0]  out_r;
  logic        out_dz;
  logic        out_ovf;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  divider_seq_ctrl #(.APPROX_ROWS(AR)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_n      (in_n),
    .in_d      (in_d),
    .in_approx (in_approx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_r     (out_r),
    .out_dz    (out_dz),
    .out_ovf   (out_ovf)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Long division digit by digit. Approximate rows always yield a 1 quotient bit,
  // and their alternating borrow chain (borrow into bit j is 1 for odd j)
  // makes the difference t ^ d ^ 8'hAA.
  function automatic void ref_div(input logic [15:0] n, input logic [7:0] d, input bit a,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output bit dz, output bit ovf);
    int rem, tv;
    dz = 0; ovf = 0; q = 0; r = 0;
    if (d == 0) begin
      dz = 1; q = 8'hFF; r = n[7:0]; return;
    end
    if (int'(n[15:8]) >= int'(d)) begin
      ovf = 1; q = 8'hFF; r = n[7:0]; return;
    end
    rem = int'(n[15:8]);
    for (int k = 7; k >= 0; k--) begin
      tv = rem * 2 + int'(n[k]);
      if (a && k < AR) begin
        q[k] = 1'b1;
        rem  = (tv & 255) ^ int'(d) ^ 32'hAA;
      end else if (tv >= int'(d)) begin
        q[k] = 1'b1;
        rem  = (tv - int'(d)) & 255;
      end else begin
        q[k] = 1'b0;
        rem  = tv & 255;
      end
    end
    r = rem[7:0];
  endfunction

  // Drives one operation; called at #1 after a rising edge. hold = cycles to
  // keep out_ready low in DONE while a competing request is offered.
  task automatic run_op(input logic [15:0] n, input logic [7:0] d, input bit a,
                        input int hold, input string tag);
    logic [7:0] eq, er;
    bit edz, eovf;
    int lat, waited;
    ref_div(n, d, a, eq, er, edz, eovf);
    in_n = n; in_d = d; in_approx = a; in_valid = 1'b1; out_ready = 1'b0;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1; waited++;
    end
    if (!in_ready) begin
      check_val({tag, " accept_timeout"}, 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_n = $urandom; in_d = $urandom;
    lat = 1;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1; lat++;
    end
    check_val({tag, " latency"}, lat, (edz || eovf) ? 1 : 9);
    check_val({tag, " q"},   out_q,   eq);
    check_val({tag, " r"},   out_r,   er);
    check_val({tag, " dz"},  out_dz,  edz);
    check_val({tag, " ovf"}, out_ovf, eovf);
    if (hold > 0) begin
      in_valid = 1'b1; in_n = 16'h0001; in_d = 8'h03; in_approx = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check_val({tag, " hold valid"}, out_valid, 1);
        check_val({tag, " hold ready"}, in_ready,  0);
        check_val({tag, " hold q"},     out_q,     eq);
        check_val({tag, " hold r"},     out_r,     er);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val({tag, " release valid"}, out_valid, 0);
    check_val({tag, " release ready"}, in_ready,  1);
  endtask

  initial begin
    logic [15:0] rn;
    logic [7:0]  rd;
    rst = 1'b1; in_valid = 1'b0; in_n = '0; in_d = '0; in_approx = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset out_valid", out_valid, 0);
    check_val("reset in_ready",  in_ready,  0);
    check_val("reset q",         out_q,     0);
    check_val("reset r",         out_r,     0);
    check_val("reset dz",        out_dz,    0);
    check_val("reset ovf",       out_ovf,   0);
    rst = 1'b0;
    #1;
    check_val("post-reset in_ready", in_ready, 1);

    run_op(16'h0064, 8'd7,  1'b0, 0, "t1 100/7");
    check_val("t1 q const", out_q, 8'd14);
    run_op(16'h1234, 8'h00, 1'b0, 0, "t2 dz");
    run_op(16'h0A00, 8'h0A, 1'b0, 0, "t3 ovf edge");
    run_op(16'h09FF, 8'h0A, 1'b0, 0, "t3 below ovf");
    run_op(16'h0064, 8'd7,  1'b1, 0, "t4 approx");
    check_val("t4 q low rows", {26'd0, out_q[5:0]}, 32'h3F);
    run_op(16'h0000, 8'h00, 1'b1, 0, "dz priority");
    run_op(16'h0064, 8'd7,  1'b0, 5, "t5 stall");

    // Abort mid-iteration: accept, then reset while the k=3 row is active.
    in_n = 16'h0064; in_d = 8'd7; in_approx = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("t6 abort valid", out_valid, 0);
    check_val("t6 abort ready", in_ready,  0);
    rst = 1'b0;
    #1;
    check_val("t6 idle ready", in_ready, 1);
    run_op(16'd255, 8'd16, 1'b0, 0, "t6 after abort");

    for (int i = 0; i < 40; i++) begin
      rn = 16'($urandom);
      rd = 8'($urandom);
      case ($urandom_range(0, 7))
        0: rd = 8'h00;
        1: rn[15:8] = rd;
        2: rn[15:8] = 8'($urandom_range(0, 3));
        default: if (rd != 0) rn[15:8] = 8'(int'(rn[15:8]) % int'(rd));
      endcase
      run_op(rn, rd, 1'($urandom_range(0, 1)), (i % 9 == 0) ? 2 : 0, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
